// File: rtl/cini_unmask_vote.sv
// Unmasking and voting stage at the boundary of the CINI-protected datapath.
// Takes three redundant copies of 2-share masked data, recombines each copy
// and majority-votes the copies. Any disagreement among the copies is flagged
// as a fault, counted, and can drive the block into a lockdown state that
// zeroes the unmasked output.
//
// Pipeline: A (share capture) -> B (per-copy recombine) -> C (vote/outputs)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | normal operation, voted data passes through
// LOCKED | a fault was seen with suppression enabled; output forced to zero
module cini_unmask_vote #(
    parameter int D                 = 1,
    parameter bit SUPPRESS_ON_FAULT = 1'b1,
    parameter int CNT_W             = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3*D-1:0]     port_in_0,
    input  logic [3*D-1:0]     port_in_1,
    input  logic               port_in_valid,
    output logic [D-1:0]       port_out,
    output logic               port_out_valid,
    output logic               port_mismatch,
    output logic               port_alarm,
    output logic               port_locked,
    output logic [CNT_W-1:0]   port_fault_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [3*D-1:0]   share0_a, share1_a;
    logic             valid_a;
    logic [3*D-1:0]   x_b;
    logic             valid_b;

    logic [D-1:0]     x0, x1, x2;
    logic [D-1:0]     vote;
    logic             beat_fault;

    logic [D-1:0]     out_nxt;
    logic             mismatch_nxt;
    logic             alarm_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Stage A: capture both shares untouched so no recombined value exists
    // combinationally ahead of the first register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            share0_a <= '0;
            share1_a <= '0;
            valid_a  <= 1'b0;
        end else begin
            valid_a <= port_in_valid;
            if (port_in_valid) begin
                share0_a <= port_in_0;
                share1_a <= port_in_1;
            end
        end
    end

    // Stage B: recombine the two shares of every copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_b     <= '0;
            valid_b <= 1'b0;
        end else begin
            valid_b <= valid_a;
            if (valid_a) begin
                x_b <= share0_a ^ share1_a;
            end
        end
    end

    assign x0 = x_b[0*D +: D];
    assign x1 = x_b[1*D +: D];
    assign x2 = x_b[2*D +: D];

    assign vote       = (x0 & x1) | (x0 & x2) | (x1 & x2);
    assign beat_fault = |((x0 ^ x1) | (x0 ^ x2));

    // Next-state and Stage C output values; registered values hold on bubbles.
    always_comb begin
        state_nxt    = state;
        out_nxt      = port_out;
        mismatch_nxt = port_mismatch;
        alarm_nxt    = port_alarm;
        cnt_nxt      = port_fault_cnt;
        if (valid_b) begin
            mismatch_nxt = beat_fault;
            out_nxt      = vote;
            // The faulty beat itself is already suppressed, not only later ones.
            if (SUPPRESS_ON_FAULT && (beat_fault || state == LOCKED)) begin
                out_nxt = '0;
            end
            if (beat_fault) begin
                alarm_nxt = 1'b1;
                if (port_fault_cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = port_fault_cnt + CNT_W'(1);
                end
                if (SUPPRESS_ON_FAULT) begin
                    state_nxt = LOCKED;
                end
            end
        end
    end

    // Stage C registers and FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            port_out       <= '0;
            port_out_valid <= 1'b0;
            port_mismatch  <= 1'b0;
            port_alarm     <= 1'b0;
            port_fault_cnt <= '0;
        end else begin
            state          <= state_nxt;
            port_out       <= out_nxt;
            port_out_valid <= valid_b;
            port_mismatch  <= mismatch_nxt;
            port_alarm     <= alarm_nxt;
            port_fault_cnt <= cnt_nxt;
        end
    end

    assign port_locked = (state == LOCKED);

endmodule

// File: tb/tb_cini_unmask_vote.sv
// Directed bench for cini_unmask_vote. Three instances share one stimulus:
//   u_s1 : D=1, suppression on,  8-bit counter
//   u_s0 : D=1, suppression off, 8-bit counter
//   u_c2 : D=1, suppression on,  2-bit counter (saturation)
// A beat driven at a falling edge is sampled on the next rising edge and is
// visible on the outputs three falling edges after it was driven.
module tb_cini_unmask_vote;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in0, in1;
    logic       vin;

    logic       s1_out, s1_v, s1_mm, s1_al, s1_lk;
    logic [7:0] s1_cnt;
    logic       s0_out, s0_v, s0_mm, s0_al, s0_lk;
    logic [7:0] s0_cnt;
    logic       c2_out, c2_v, c2_mm, c2_al, c2_lk;
    logic [1:0] c2_cnt;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cini_unmask_vote #(.D(1), .SUPPRESS_ON_FAULT(1'b1), .CNT_W(8)) u_s1 (
        .clk(clk), .reset(rst), .port_in_0(in0), .port_in_1(in1),
        .port_in_valid(vin), .port_out(s1_out), .port_out_valid(s1_v),
        .port_mismatch(s1_mm), .port_alarm(s1_al), .port_locked(s1_lk),
        .port_fault_cnt(s1_cnt)
    );

    cini_unmask_vote #(.D(1), .SUPPRESS_ON_FAULT(1'b0), .CNT_W(8)) u_s0 (
        .clk(clk), .reset(rst), .port_in_0(in0), .port_in_1(in1),
        .port_in_valid(vin), .port_out(s0_out), .port_out_valid(s0_v),
        .port_mismatch(s0_mm), .port_alarm(s0_al), .port_locked(s0_lk),
        .port_fault_cnt(s0_cnt)
    );

    cini_unmask_vote #(.D(1), .SUPPRESS_ON_FAULT(1'b1), .CNT_W(2)) u_c2 (
        .clk(clk), .reset(rst), .port_in_0(in0), .port_in_1(in1),
        .port_in_valid(vin), .port_out(c2_out), .port_out_valid(c2_v),
        .port_mismatch(c2_mm), .port_alarm(c2_al), .port_locked(c2_lk),
        .port_fault_cnt(c2_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // k: 0 = u_s0, 1 = u_s1, 2 = u_c2
    task automatic check_dut(input string tag, input int k, input logic ev, input logic eo,
                             input logic emm, input logic eal, input logic elk,
                             input logic [7:0] ecnt);
        logic       v, o, mm, al, lk;
        logic [7:0] cnt;
        case (k)
            0:       begin v = s0_v; o = s0_out; mm = s0_mm; al = s0_al; lk = s0_lk; cnt = s0_cnt; end
            1:       begin v = s1_v; o = s1_out; mm = s1_mm; al = s1_al; lk = s1_lk; cnt = s1_cnt; end
            default: begin v = c2_v; o = c2_out; mm = c2_mm; al = c2_al; lk = c2_lk; cnt = {6'b0, c2_cnt}; end
        endcase
        chk($sformatf("%s/dut%0d/valid", tag, k), {31'b0, v}, {31'b0, ev});
        chk($sformatf("%s/dut%0d/out", tag, k), {31'b0, o}, {31'b0, eo});
        chk($sformatf("%s/dut%0d/mismatch", tag, k), {31'b0, mm}, {31'b0, emm});
        chk($sformatf("%s/dut%0d/alarm", tag, k), {31'b0, al}, {31'b0, eal});
        chk($sformatf("%s/dut%0d/locked", tag, k), {31'b0, lk}, {31'b0, elk});
        chk($sformatf("%s/dut%0d/cnt", tag, k), {24'b0, cnt}, {24'b0, ecnt});
    endtask

    // Same expectation on all three instances.
    task automatic check_all(input string tag, input logic ev, input logic eo, input logic emm,
                             input logic eal, input logic elk, input logic [7:0] ecnt);
        for (int k = 0; k < 3; k++) check_dut(tag, k, ev, eo, emm, eal, elk, ecnt);
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic v);
        @(negedge clk);
        in0 = a;
        in1 = b;
        vin = v;
    endtask

    task automatic idle();
        drive(3'b000, 3'b000, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in0 = 3'b000;
        in1 = 3'b000;
        vin = 1'b0;
        @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 8'd0);
        rst = 1'b0;

        // Clean back-to-back beats: x = 111, 000, 111
        drive(3'b101, 3'b010, 1'b1);
        drive(3'b000, 3'b000, 1'b1);
        drive(3'b111, 3'b000, 1'b1);
        idle(); check_all("clean_a", 1, 1, 0, 0, 0, 8'd0);
        idle(); check_all("clean_b", 1, 0, 0, 0, 0, 8'd0);
        idle(); check_all("clean_c", 1, 1, 0, 0, 0, 8'd0);
        idle(); check_all("clean_end", 0, 1, 0, 0, 0, 8'd0);

        // Valid pattern 1,0,1,1; bubble carries data that would vote 0
        drive(3'b111, 3'b000, 1'b1);
        drive(3'b000, 3'b000, 1'b0);
        drive(3'b000, 3'b000, 1'b1);
        drive(3'b101, 3'b010, 1'b1); check_all("vpat_1", 1, 1, 0, 0, 0, 8'd0);
        idle();                      check_all("vpat_bubble", 0, 1, 0, 0, 0, 8'd0);
        idle();                      check_all("vpat_3", 1, 0, 0, 0, 0, 8'd0);
        idle();                      check_all("vpat_4", 1, 1, 0, 0, 0, 8'd0);
        idle();                      check_all("vpat_end", 0, 1, 0, 0, 0, 8'd0);

        // Copy 1 flipped: x = 1,0,1 -> vote 1, mismatch; then a clean 1
        drive(3'b111, 3'b010, 1'b1);
        drive(3'b111, 3'b000, 1'b1);
        idle();
        idle();
        check_dut("fault1", 1, 1, 0, 1, 1, 1, 8'd1);
        check_dut("fault1", 0, 1, 1, 1, 1, 0, 8'd1);
        check_dut("fault1", 2, 1, 0, 1, 1, 1, 8'd1);
        idle();
        check_dut("after_fault", 1, 1, 0, 0, 1, 1, 8'd1);
        check_dut("after_fault", 0, 1, 1, 0, 1, 0, 8'd1);
        check_dut("after_fault", 2, 1, 0, 0, 1, 1, 8'd1);

        // Four more faulty beats on varying copies
        drive(3'b111, 3'b010, 1'b1);  // x=101 vote 1
        drive(3'b000, 3'b001, 1'b1);  // x=001 vote 0 (copy 0 flipped)
        drive(3'b110, 3'b000, 1'b1);  // x=110 vote 1 (copy 0 flipped)
        drive(3'b111, 3'b010, 1'b1);  // x=101 vote 1
        check_dut("fault2", 1, 1, 0, 1, 1, 1, 8'd2);
        check_dut("fault2", 0, 1, 1, 1, 1, 0, 8'd2);
        check_dut("fault2", 2, 1, 0, 1, 1, 1, 8'd2);
        idle();
        check_dut("fault3", 1, 1, 0, 1, 1, 1, 8'd3);
        check_dut("fault3", 0, 1, 0, 1, 1, 0, 8'd3);
        check_dut("fault3", 2, 1, 0, 1, 1, 1, 8'd3);
        idle();
        check_dut("fault4", 1, 1, 0, 1, 1, 1, 8'd4);
        check_dut("fault4", 0, 1, 1, 1, 1, 0, 8'd4);
        check_dut("fault4", 2, 1, 0, 1, 1, 1, 8'd3);
        idle();
        check_dut("fault5", 1, 1, 0, 1, 1, 1, 8'd5);
        check_dut("fault5", 0, 1, 1, 1, 1, 0, 8'd5);
        check_dut("fault5", 2, 1, 0, 1, 1, 1, 8'd3);

        // Reset with two beats in flight while locked
        drive(3'b111, 3'b000, 1'b1);
        drive(3'b111, 3'b000, 1'b1);
        rst = 1'b1;
        vin = 1'b0;
        #1;
        check_all("rst_async", 0, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        check_all("rst_release", 0, 0, 0, 0, 0, 8'd0);
        drive(3'b101, 3'b010, 1'b1);
        idle(); check_all("rst_flush1", 0, 0, 0, 0, 0, 8'd0);
        idle(); check_all("rst_flush2", 0, 0, 0, 0, 0, 8'd0);
        idle(); check_all("post_rst", 1, 1, 0, 0, 0, 8'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
